// File: rtl/kyber_pkg.sv
// Shared Kyber constants for the coefficient datapath blocks.
package kyber_pkg;
  localparam int KYBER_Q  = 3329;
  localparam int KYBER_2Q = 6658;
  localparam int KYBER_N  = 256;
  localparam int COEF_W   = 12;
  localparam int IDX_W    = 8;
endpackage

// File: rtl/poly_mod_add_stage.sv
// One registered conditional-subtract stage with valid/ready handshake; carries
// the coefficient index alongside the data.
module poly_mod_add_stage
  import kyber_pkg::*;
#(
  parameter int DATA_W = COEF_W + 2,
  parameter int OUT_W  = COEF_W + 2,
  parameter int IDX_B  = IDX_W,
  parameter int SUB    = KYBER_2Q
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_B-1:0]  in_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [IDX_B-1:0]  out_idx
);
  localparam logic [DATA_W-1:0] SUB_V = DATA_W'(SUB);

  function automatic logic [OUT_W-1:0] reduce(input logic [DATA_W-1:0] x);
    return (x >= SUB_V) ? OUT_W'(x - SUB_V) : OUT_W'(x);
  endfunction

  // Loads whenever empty or the held result leaves this cycle.
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= reduce(in_data);
        out_idx  <= in_idx;
      end
    end
  end
endmodule

// File: rtl/poly_mod_add_stream.sv
// Streaming (a + b) mod q engine: adder and index/framing tracking up front,
// then two conditional-subtract stages (2q, then q) with full backpressure.
module poly_mod_add_stream
  import kyber_pkg::*;
#(
  parameter int WIDTH = COEF_W,
  parameter int Q     = KYBER_Q,
  parameter int N     = KYBER_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_sum,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 err_frame
);
  localparam int IW = $clog2(N);
  localparam int SW = WIDTH + 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [SW-1:0] sum_p0;
  logic [IW-1:0] in_cnt;
  logic          in_xfer;
  logic          vld_p1;
  logic [SW-1:0] sum_p1;
  logic [IW-1:0] idx_p1;
  logic          rdy_p2;

  assign sum_p0  = {2'b00, in_a} + {2'b00, in_b};
  assign in_xfer = in_valid & in_ready;

  // Framing is only observed, never used to resynchronise the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt    <= '0;
      err_frame <= 1'b0;
    end else if (in_xfer) begin
      in_cnt <= in_cnt + 1'b1;
      if (in_last != (in_cnt == LAST_IDX)) err_frame <= 1'b1;
    end
  end

  // ---- stage 1: fold s0 below 2q ----
  poly_mod_add_stage #(
    .DATA_W(SW), .OUT_W(SW), .IDX_B(IW), .SUB(2 * Q)
  ) u_stage_p1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (sum_p0),
    .in_idx   (in_cnt),
    .out_valid(vld_p1),
    .out_ready(rdy_p2),
    .out_data (sum_p1),
    .out_idx  (idx_p1)
  );

  // ---- stage 2: fold s1 below q, narrow to coefficient width ----
  poly_mod_add_stage #(
    .DATA_W(SW), .OUT_W(WIDTH), .IDX_B(IW), .SUB(Q)
  ) u_stage_p2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (vld_p1),
    .in_ready (rdy_p2),
    .in_data  (sum_p1),
    .in_idx   (idx_p1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_sum),
    .out_idx  (out_idx)
  );

  assign out_last = (out_idx == LAST_IDX);
endmodule

// File: tb/tb_poly_mod_add_stream.sv
// Directed and randomised checks of poly_mod_add_stream against an in-order
// scoreboard and hand-computed sums.
module tb_poly_mod_add_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_a = '0;
  logic [11:0] in_b = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_sum;
  logic [7:0]  out_idx;
  logic        out_last;
  logic        err_frame;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_out = 0;
  int n_last = 0;
  int mdl_cnt = 0;
  logic mdl_err = 1'b0;
  logic rnd_ready = 1'b0;
  logic fix_ready = 1'b1;

  typedef struct { int sum; int idx; } exp_t;
  exp_t q[$];

  poly_mod_add_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_idx(out_idx),
    .out_last(out_last), .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #2;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : fix_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard and framing model, sampled away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    chk("err_frame", 32'(err_frame), 32'(mdl_err));
    if (rst) begin
      q.delete();
      mdl_cnt = 0;
      mdl_err = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        e.sum = (int'(in_a) + int'(in_b)) % 3329;
        e.idx = mdl_cnt;
        q.push_back(e);
        if (in_last != (mdl_cnt == 255)) mdl_err = 1'b1;
        mdl_cnt = (mdl_cnt + 1) % 256;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("sb_sum", 32'(out_sum), 32'(e.sum));
          chk("sb_idx", 32'(out_idx), 32'(e.idx));
          chk("sb_last", 32'(out_last), 32'(e.idx == 255));
          chk("sb_range", 32'(out_sum < 12'd3329), 1);
          n_out++;
          if (out_last) n_last++;
        end
      end
    end
  end

  function automatic logic ok_last();
    return mdl_cnt == 255;
  endfunction

  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic last);
    int guard = 0;
    logic acc;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 200) chk("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic basic(input logic [11:0] a, input logic [11:0] b, input int exp_sum);
    send(a, b, ok_last());
    chk("lat_t1_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_t2_valid", 32'(out_valid), 1);
    chk("basic_sum", 32'(out_sum), 32'(exp_sum));
    wait_drain();
  endtask

  initial begin
    int c0, o0, acc, hs, hi;
    logic took, seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_err", 32'(err_frame), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    basic(12'd3000, 12'd1000, 671);
    basic(12'd4095, 12'd4095, 1532);
    basic(12'd0, 12'd0, 0);
    basic(12'd3328, 12'd1, 0);
    basic(12'd3328, 12'd3329, 3328);

    // full polynomial at one pair per cycle
    do_reset();
    c0 = cyc; o0 = n_out; n_last = 0;
    for (int i = 0; i < 256; i++)
      send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), i == 255);
    chk("poly_cycles", 32'(cyc - c0), 256);
    wait_drain();
    chk("poly_outputs", 32'(n_out - o0), 256);
    chk("poly_last_count", 32'(n_last), 1);
    chk("poly_err", 32'(err_frame), 0);

    // backpressure: downstream stalled for 10 cycles
    fix_ready = 1'b0;
    @(posedge clk); #1;
    acc = 0; seen = 1'b0; hs = 0; hi = 0;
    in_valid = 1'b1; in_a = 12'd2000; in_b = 12'd2000; in_last = ok_last();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      took = in_ready;
      if (took) acc++;
      if (out_valid) begin
        if (!seen) begin seen = 1'b1; hs = int'(out_sum); hi = int'(out_idx); end
        else begin
          chk("bp_hold_sum", 32'(out_sum), 32'(hs));
          chk("bp_hold_idx", 32'(out_idx), 32'(hi));
        end
      end
      @(posedge clk); #1;
      if (took) begin in_a = in_a + 12'd7; in_b = 12'd4095; in_last = ok_last(); end
    end
    chk("bp_accepted", 32'(acc), 2);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_held_sum", 32'(hs), 671);
    in_valid = 1'b0;
    fix_ready = 1'b1;
    wait_drain();

    // framing error at index 100, then through the wrap
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
           (i == 100) ? 1'b1 : ok_last());
      if (i == 99) chk("frame_before", 32'(err_frame), 0);
      if (i == 100) chk("frame_set", 32'(err_frame), 1);
    end
    wait_drain();
    chk("frame_sticky", 32'(err_frame), 1);

    // reset with two pairs in flight
    do_reset();
    for (int i = 0; i < 50; i++)
      send(12'(i * 61), 12'(i * 13), (i == 10) ? 1'b1 : ok_last());
    chk("mid_err_pre", 32'(err_frame), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_out_valid", 32'(out_valid), 0);
    chk("mid_err", 32'(err_frame), 0);
    chk("mid_in_ready", 32'(in_ready), 1);
    send(12'd5, 12'd7, 1'b0);
    @(posedge clk); #1;
    chk("mid_next_valid", 32'(out_valid), 1);
    chk("mid_next_idx", 32'(out_idx), 0);
    chk("mid_next_sum", 32'(out_sum), 12);
    wait_drain();

    // random traffic with random downstream stalls
    do_reset();
    rnd_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), ok_last());
    end
    rnd_ready = 1'b0;
    fix_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wait_drain();
    chk("rand_err", 32'(err_frame), 0);
    chk("rand_queue_empty", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
